mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-master to one-slave arbiter that sits directly upstream of the single-port `memory` block.
- Connects the instruction-fetch port (i_) and the load/store port (d_) to one memory port (m_) using the same valid/ready/rvalid protocol as `memory`.
- Exactly one transaction is outstanding at a time.
- Round-robin grant when both masters request in the same cycle; the memory response is routed back to the master that issued the request.

Parameters:
- DATA_WIDTH, 64, data bus width in bits, multiple of 8.
- ADDR_WIDTH, 16, word address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- i_valid  in  1  instruction master request.
- i_ready  out  1  instruction request accepted this cycle.
- i_wen  in  1  instruction write enable.
- i_addr  in  ADDR_WIDTH  instruction word address.
- i_wdata  in  DATA_WIDTH  instruction write data.
- i_wmask  in  DATA_WIDTH/8  instruction byte mask.
- i_rvalid  out  1  instruction response strobe.
- i_rdata  out  DATA_WIDTH  instruction response data.
- d_valid, d_ready, d_wen, d_addr, d_wdata, d_wmask, d_rvalid, d_rdata: same widths and meaning, data master.
- m_valid  out  1  request to memory.
- m_ready  in  1  memory idle.
- m_wen, m_addr, m_wdata, m_wmask  out  —  forwarded payload of the granted master.
- m_rvalid  in  1  memory response strobe.
- m_rdata  in  DATA_WIDTH  memory response data.

Behaviour:
- Reset: clk, rst synchronous active-low. While rst=0, state<=IDLE and last_grant<=D. i_ready, d_ready, m_valid, i_rvalid and d_rvalid are forced 0 combinationally during reset.
- State machine: IDLE, WAIT_I, WAIT_D.
- Grant in IDLE (combinational):
  - Only i_valid → I. Only d_valid → D.
  - Both valid → the master that is not last_grant.
  - Neither → no grant.
- Outputs in IDLE:
  - m_valid = i_valid | d_valid.
  - m_wen/m_addr/m_wdata/m_wmask = payload of the granted master; all zero when no grant.
  - Granted master's ready = m_ready; the other master's ready = 0.
- Acceptance: m_valid & m_ready at a rising edge. The arbiter then moves to WAIT_I or WAIT_D per grant, and last_grant <= granted master.
- WAIT_x:
  - m_valid=0, i_ready=0, d_ready=0; payload outputs are zero.
  - The pending request's payload is not held on m_: `memory` latches the address at acceptance.
  - On m_rvalid=1: x_rvalid=1 combinationally in that same cycle, and state <= IDLE. The next request can be accepted on the following edge.
- Data routing: i_rdata and d_rdata are both driven from m_rdata unconditionally; only the rvalid strobes are steered.
- Latency seen by the master:
  - Read: accept at edge t → x_rvalid high in cycle t+1.
  - Write: accept at t → memory write state in t+1 → x_rvalid in cycle t+2, with rdata = pre-write word.
- Throughput: a master receiving rvalid in cycle c may be accepted at the end of cycle c+1 at the earliest.
- Master obligation: hold valid and payload stable until ready=1. Dropping valid before acceptance is permitted and causes no memory access.
- m_rvalid while in IDLE (spurious, or left over from before reset): ignored, neither rvalid asserted.
- m_ready=0 in IDLE: no acceptance, grant re-evaluated every cycle, last_grant unchanged.
- Reset in WAIT_x: the outstanding transaction is abandoned; no rvalid is issued after reset.
- Fairness: with both masters continuously valid, grants alternate I, D, I, D… starting with I after reset.

Test Plan:
- Single I read: mem[0x10]=0xDEAD; i_valid=1, i_wen=0, i_addr=0x10 → i_ready=1 in the accept cycle; i_rvalid=1 with i_rdata=0xDEAD exactly 1 cycle later; d_rvalid stays 0.
- D write then read: d write addr 0x20, wdata=0x1122334455667788, wmask=0x0F, old word 0xFFFF…FF → d_rvalid 2 cycles after accept. Following d read returns 0xFFFFFFFF55667788.
- Simultaneous requests: i_valid=d_valid=1 held for 4 transactions after reset → accepted order I, D, I, D; each rvalid appears only on the matching master.
- Back-pressure: d_valid raised while the I transaction is in WAIT_I → d_ready=0 until the cycle after i_rvalid, then d accepted; payload is observed on m_ only from that cycle.
- Reset mid-transaction: assert rst=0 for one cycle during WAIT_D of a write → no d_rvalid afterwards; state IDLE; next simultaneous request is granted to I.
- Spurious response: force m_rvalid=1 in IDLE with no request → i_rvalid=d_rvalid=0, state unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (instruction fetch i_, load/store d_) to one-slave
// arbiter placed directly in front of the single-port memory block.
// Only one transaction is outstanding at a time. When both masters request
// in the same cycle, the grant goes round-robin. The response strobe is
// steered back to the master that issued the request.
//
// State table:
//   state  | meaning
//   IDLE   | no transaction outstanding, grant evaluated every cycle
//   WAIT_I | instruction request accepted, waiting for m_rvalid
//   WAIT_D | data request accepted, waiting for m_rvalid
//
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   i_valid/i_ready             instruction master request handshake
//   i_wen/i_addr/i_wdata/i_wmask  instruction master payload
//   i_rvalid/i_rdata            instruction master response
//   d_*                         same set of signals for the data master
//   m_valid/m_ready             request handshake towards memory
//   m_wen/m_addr/m_wdata/m_wmask  payload forwarded from the granted master
//   m_rvalid/m_rdata            memory response
module mem_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  output logic                      i_ready,
  input  logic                      i_wen,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  input  logic [DATA_WIDTH-1:0]     i_wdata,
  input  logic [DATA_WIDTH/8-1:0]   i_wmask,
  output logic                      i_rvalid,
  output logic [DATA_WIDTH-1:0]     i_rdata,
  input  logic                      d_valid,
  output logic                      d_ready,
  input  logic                      d_wen,
  input  logic [ADDR_WIDTH-1:0]     d_addr,
  input  logic [DATA_WIDTH-1:0]     d_wdata,
  input  logic [DATA_WIDTH/8-1:0]   d_wmask,
  output logic                      d_rvalid,
  output logic [DATA_WIDTH-1:0]     d_rdata,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_wen,
  output logic [ADDR_WIDTH-1:0]     m_addr,
  output logic [DATA_WIDTH-1:0]     m_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_wmask,
  input  logic                      m_rvalid,
  input  logic [DATA_WIDTH-1:0]     m_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   grant_i, grant_d;
  logic   in_idle;

  // Reset is folded into in_idle so that every handshake and strobe output
  // is forced low while rst is asserted, independent of the flop contents.
  assign in_idle = rst && (state_q == IDLE);

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (in_idle) begin
      // On a tie the master that did not win last time gets the grant.
      if (i_valid && (!d_valid || (last_grant_q == GRANT_D))) begin
        grant_i = 1'b1;
      end else if (d_valid) begin
        grant_d = 1'b1;
      end
    end
  end

  always_comb begin
    m_valid = in_idle && (i_valid || d_valid);
    i_ready = grant_i && m_ready;
    d_ready = grant_d && m_ready;

    m_wen   = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_wmask = '0;
    if (grant_i) begin
      m_wen   = i_wen;
      m_addr  = i_addr;
      m_wdata = i_wdata;
      m_wmask = i_wmask;
    end else if (grant_d) begin
      m_wen   = d_wen;
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_wmask = d_wmask;
    end

    // A response arriving while idle has no owner and is dropped.
    i_rvalid = rst && (state_q == WAIT_I) && m_rvalid;
    d_rvalid = rst && (state_q == WAIT_D) && m_rvalid;
    i_rdata  = m_rdata;
    d_rdata  = m_rdata;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (m_valid && m_ready) begin
          state_d      = grant_i ? WAIT_I : WAIT_D;
          last_grant_d = grant_i ? GRANT_I : GRANT_D;
        end
      end
      WAIT_I, WAIT_D: begin
        if (m_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // last_grant resets to D so the first contested grant after reset goes to I.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural model of the
// single-port memory behind it (read: response one cycle after accept;
// write: one write cycle, then response carrying the pre-write word).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_ready, i_wen, i_rvalid;
  logic [15:0] i_addr;
  logic [63:0] i_wdata, i_rdata;
  logic [7:0]  i_wmask;
  logic        d_valid, d_ready, d_wen, d_rvalid;
  logic [15:0] d_addr;
  logic [63:0] d_wdata, d_rdata;
  logic [7:0]  d_wmask;
  logic        m_valid, m_ready, m_wen, m_rvalid;
  logic [15:0] m_addr;
  logic [63:0] m_wdata, m_rdata;
  logic [7:0]  m_wmask;

  logic        force_rv;
  logic        stall;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_wen(i_wen), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_wmask(i_wmask), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_ready(d_ready), .d_wen(d_wen), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wmask(d_wmask), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_wen(m_wen), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wmask(m_wmask), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  // Memory model: 0 idle, 1 write cycle, 2 response cycle.
  logic [63:0] mem [256];
  int          mst = 0;
  bit          mem_init = 1'b0;
  logic [63:0] resp_q = '0;
  logic [7:0]  wa_q;
  logic [63:0] wd_q;
  logic [7:0]  wm_q;

  function automatic logic [63:0] merge(input logic [63:0] old_w,
                                        input logic [63:0] new_w,
                                        input logic [7:0] mask);
    logic [63:0] r;
    r = old_w;
    for (int b = 0; b < 8; b++) begin
      if (mask[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

  assign m_ready  = (mst == 0) && !stall;
  assign m_rvalid = (mst == 2) || force_rv;
  assign m_rdata  = resp_q;

  always @(posedge clk) begin
    if (!mem_init) begin
      mem[8'h10] <= 64'hDEAD;
      mem[8'h20] <= '1;
      mem[8'h30] <= 64'h3030;
      mem_init   <= 1'b1;
    end else begin
      case (mst)
        0: if (m_valid && m_ready) begin
          resp_q <= mem[m_addr[7:0]];
          wa_q   <= m_addr[7:0];
          wd_q   <= m_wdata;
          wm_q   <= m_wmask;
          mst    <= m_wen ? 1 : 2;
        end
        1: begin
          mem[wa_q] <= merge(mem[wa_q], wd_q, wm_q);
          mst       <= 2;
        end
        default: mst <= 0;
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b0; force_rv = 1'b0; stall = 1'b0;
    i_valid = 0; i_wen = 0; i_addr = '0; i_wdata = '0; i_wmask = '0;
    d_valid = 0; d_wen = 0; d_addr = '0; d_wdata = '0; d_wmask = '0;

    // Reset forces handshakes low even with requests pending.
    @(negedge clk); i_valid = 1; d_valid = 1; #1;
    check_eq("rst_i_ready", i_ready, 0);
    check_eq("rst_d_ready", d_ready, 0);
    check_eq("rst_m_valid", m_valid, 0);
    @(negedge clk); rst = 1; i_valid = 0; d_valid = 0;

    // Single instruction read of 0x10.
    @(negedge clk); i_valid = 1; i_addr = 16'h10; #1;
    check_eq("t1_i_ready", i_ready, 1);
    check_eq("t1_d_ready", d_ready, 0);
    check_eq("t1_m_valid", m_valid, 1);
    check_eq("t1_m_addr", m_addr, 16'h10);
    @(negedge clk); i_valid = 0; #1;
    check_eq("t1_i_rvalid", i_rvalid, 1);
    check_eq("t1_i_rdata", i_rdata, 64'hDEAD);
    check_eq("t1_d_rvalid", d_rvalid, 0);

    // Data write to 0x20 with low-half mask, then read back.
    @(negedge clk); d_valid = 1; d_wen = 1; d_addr = 16'h20;
    d_wdata = 64'h1122334455667788; d_wmask = 8'h0F; #1;
    check_eq("t2_d_ready", d_ready, 1);
    check_eq("t2_m_wen", m_wen, 1);
    check_eq("t2_m_wdata", m_wdata, 64'h1122334455667788);
    check_eq("t2_m_wmask", m_wmask, 8'h0F);
    @(negedge clk); d_valid = 0; d_wen = 0; #1;
    check_eq("t2_wr_d_rvalid", d_rvalid, 0);
    check_eq("t2_wr_m_valid", m_valid, 0);
    @(negedge clk); #1;
    check_eq("t2_wr_rvalid", d_rvalid, 1);
    check_eq("t2_wr_rdata", d_rdata, 64'hFFFFFFFFFFFFFFFF);
    @(negedge clk); d_valid = 1; d_addr = 16'h20; #1;
    check_eq("t2_rd_ready", d_ready, 1);
    check_eq("t2_rd_m_wen", m_wen, 0);
    @(negedge clk); d_valid = 0; #1;
    check_eq("t2_rd_rvalid", d_rvalid, 1);
    check_eq("t2_rd_rdata", d_rdata, 64'hFFFFFFFF55667788);

    // Simultaneous requests after reset: I, D, I, D.
    @(negedge clk); rst = 0;
    @(negedge clk); rst = 1;
    i_valid = 1; i_addr = 16'h10; d_valid = 1; d_addr = 16'h30;
    for (int k = 0; k < 4; k++) begin
      logic exp_i;
      exp_i = (k % 2 == 0);
      #1;
      check_eq($sformatf("t3_%0d_i_ready", k), i_ready, exp_i);
      check_eq($sformatf("t3_%0d_d_ready", k), d_ready, !exp_i);
      check_eq($sformatf("t3_%0d_m_addr", k), m_addr, exp_i ? 16'h10 : 16'h30);
      @(negedge clk); #1;
      check_eq($sformatf("t3_%0d_i_rvalid", k), i_rvalid, exp_i);
      check_eq($sformatf("t3_%0d_d_rvalid", k), d_rvalid, !exp_i);
      check_eq($sformatf("t3_%0d_rdata", k), i_rdata, exp_i ? 64'hDEAD : 64'h3030);
      check_eq($sformatf("t3_%0d_wait_m_valid", k), m_valid, 0);
      @(negedge clk);
    end
    i_valid = 0; d_valid = 0;

    // Back-pressure: d waits while the I transaction is outstanding.
    i_valid = 1; i_addr = 16'h10; #1;
    check_eq("t4_i_ready", i_ready, 1);
    @(negedge clk); i_valid = 0; d_valid = 1; d_addr = 16'h30; #1;
    check_eq("t4_wait_d_ready", d_ready, 0);
    check_eq("t4_wait_m_valid", m_valid, 0);
    check_eq("t4_wait_m_addr", m_addr, 16'h0);
    check_eq("t4_i_rvalid", i_rvalid, 1);
    @(negedge clk); #1;
    check_eq("t4_d_ready", d_ready, 1);
    check_eq("t4_m_addr", m_addr, 16'h30);
    @(negedge clk); d_valid = 0; #1;
    check_eq("t4_d_rvalid", d_rvalid, 1);
    check_eq("t4_d_rdata", d_rdata, 64'h3030);

    // Reset during WAIT_D of a write abandons the transaction.
    @(negedge clk); d_valid = 1; d_wen = 1; d_addr = 16'h30;
    d_wdata = 64'hAAAA; d_wmask = 8'hFF; #1;
    check_eq("t5_d_ready", d_ready, 1);
    @(negedge clk); d_valid = 0; d_wen = 0; rst = 0;
    @(negedge clk); rst = 1;
    i_valid = 1; i_addr = 16'h10; d_valid = 1; d_addr = 16'h20; #1;
    check_eq("t5_late_d_rvalid", d_rvalid, 0);
    check_eq("t5_late_i_rvalid", i_rvalid, 0);
    check_eq("t5_busy_i_ready", i_ready, 0);
    check_eq("t5_grant_addr", m_addr, 16'h10);
    @(negedge clk); #1;
    check_eq("t5_i_ready", i_ready, 1);
    check_eq("t5_d_ready", d_ready, 0);
    @(negedge clk); i_valid = 0; d_valid = 0; #1;
    check_eq("t5_i_rvalid", i_rvalid, 1);
    check_eq("t5_d_rvalid", d_rvalid, 0);

    // Spurious response in IDLE, then m_ready low holds the grant.
    @(negedge clk); force_rv = 1; #1;
    check_eq("t6_i_rvalid", i_rvalid, 0);
    check_eq("t6_d_rvalid", d_rvalid, 0);
    check_eq("t6_m_valid", m_valid, 0);
    @(negedge clk); force_rv = 0; stall = 1; i_valid = 1; d_valid = 1; #1;
    check_eq("t6_stall_m_valid", m_valid, 1);
    check_eq("t6_stall_i_ready", i_ready, 0);
    check_eq("t6_stall_d_ready", d_ready, 0);
    check_eq("t6_stall_m_addr", m_addr, 16'h20);
    @(negedge clk); #1;
    check_eq("t6_stall2_d_ready", d_ready, 0);
    stall = 0; #1;
    check_eq("t6_d_ready", d_ready, 1);
    check_eq("t6_i_ready", i_ready, 0);
    @(negedge clk); i_valid = 0; d_valid = 0; #1;
    check_eq("t6_d_rvalid", d_rvalid, 1);
    check_eq("t6_d_rdata", d_rdata, 64'hFFFFFFFF55667788);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
